fifo_circ: RTL

Parametrised synchronous FIFO built on a circular buffer with read and write pointers, replacing the shift-register-style FIFO in the UART datapath.
- Adds an occupancy level output and programmable almost-full / almost-empty thresholds.
- Adds overflow / underflow error pulses and a read-data valid strobe.
- Sits between the UART RX deserialiser and the host interface, and between the host and the TX serialiser.

---
 rtl/fifo_circ.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fifo_circ.sv
// rtl/fifo_circ.sv - circular-buffer synchronous FIFO with level, thresholds and error pulses
//
// Purpose: DEPTH = 2**NCBIT word FIFO using a wrapping read/write pointer
// pair and a separately tracked occupancy level. Used between the UART RX
// deserialiser and the host, and between the host and the TX serialiser.
//
// Optional feature macro: FIFO_FWFT_EN (first-word fall-through read port).
//   undefined : odata is registered, valid one cycle after an accepted read.
//   defined   : odata shows the head word combinationally, odata_vld = ~empty.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   idata        in   [WIDTH-1:0] write data
//   wr_en        in   write request
//   rd_en        in   read request (pop in FWFT mode)
//   odata        out  [WIDTH-1:0] read data
//   odata_vld    out  odata holds a newly popped word (head word in FWFT)
//   full         out  level == DEPTH
//   empty        out  level == 0
//   almost_full  out  level >= AFULL_THR
//   almost_empty out  level <= AEMPTY_THR
//   level        out  [NCBIT:0] words stored, 0..DEPTH
//   overflow     out  one-cycle pulse, write was rejected
//   underflow    out  one-cycle pulse, read was rejected

module fifo_circ #(
  parameter int WIDTH      = 8,
  parameter int NCBIT      = 7,
  parameter int AFULL_THR  = (1 << NCBIT) - 4,
  parameter int AEMPTY_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] idata,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] odata,
  output logic             odata_vld,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [NCBIT:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << NCBIT;

  localparam logic [NCBIT:0]   DEPTH_L  = DEPTH[NCBIT:0];
  localparam logic [NCBIT:0]   AFULL_L  = AFULL_THR[NCBIT:0];
  localparam logic [NCBIT:0]   AEMPTY_L = AEMPTY_THR[NCBIT:0];
  localparam logic [NCBIT:0]   LVL_ONE  = 1;
  localparam logic [NCBIT-1:0] PTR_ONE  = 1;

  if (AFULL_THR > DEPTH || AFULL_THR < 0) begin : g_bad_afull
    $error("fifo_circ: AFULL_THR must lie in 0..DEPTH");
  end
  if (AEMPTY_THR >= DEPTH || AEMPTY_THR < 0) begin : g_bad_aempty
    $error("fifo_circ: AEMPTY_THR must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [NCBIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [NCBIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [NCBIT:0]   level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // Flags come straight from the level register.
  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AFULL_L);
  assign almost_empty = (level_q <= AEMPTY_L);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is still accepted when a read frees a slot
  // in the same cycle. No bypass when empty: the read is rejected.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & ~rd_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= idata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; a word written into an empty FIFO
  // shows up as soon as the write edge has updated mem and level.
  assign odata     = mem[rd_ptr_q];
  assign odata_vld = ~empty;
`else
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             odata_vld_q, odata_vld_d;

  always_comb begin
    odata_d     = odata_q;
    odata_vld_d = rd_acc;
    if (rd_acc) odata_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odata_q     <= '0;
      odata_vld_q <= 1'b0;
    end else begin
      odata_q     <= odata_d;
      odata_vld_q <= odata_vld_d;
    end
  end

  assign odata     = odata_q;
  assign odata_vld = odata_vld_q;
`endif

endmodule
